// File: rtl/mem_access_pkg.sv
// Shared types and lane helpers for the MEM-stage access unit.
// Define MEM_BIG_ENDIAN_EN to select big-endian byte-lane mapping.
package mem_access_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RD   = 2'b01,
    ST_WR   = 2'b10,
    ST_RESP = 2'b11
  } state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Bit offset of the addressed byte/half inside the memory word.
  function automatic logic [4:0] lane_shift(input logic [1:0] addr, input logic [1:0] size);
    logic [4:0] sh;
    sh = 5'd0;
    case (size)
`ifdef MEM_BIG_ENDIAN_EN
      SZ_BYTE: sh = {~addr, 3'b000};
      SZ_HALF: sh = addr[1] ? 5'd0 : 5'd16;
`else
      SZ_BYTE: sh = {addr, 3'b000};
      SZ_HALF: sh = {addr[1], 4'b0000};
`endif
      default: sh = 5'd0;
    endcase
    return sh;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational lane extract/extend for loads and lane merge for sub-word stores.
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  addr_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] merge_o
);

  logic [4:0]  sh;
  logic [31:0] lane;
  logic [31:0] mask;

  always_comb begin
    sh     = lane_shift(addr_i, size_i);
    lane   = word_i >> sh;
    mask   = 32'hFFFF_FFFF;
    load_o = word_i;
    case (size_i)
      SZ_BYTE: begin
        load_o = {{24{signed_i & lane[7]}}, lane[7:0]};
        mask   = 32'h0000_00FF;
      end
      SZ_HALF: begin
        load_o = {{16{signed_i & lane[15]}}, lane[15:0]};
        mask   = 32'h0000_FFFF;
      end
      default: begin
        load_o = word_i;
        mask   = 32'hFFFF_FFFF;
      end
    endcase
    merge_o = (word_i & ~(mask << sh)) | ((wdata_i & mask) << sh);
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage initiator: byte-addressed load/store onto a word-only memory,
// with read-modify-write for sub-word stores. Honours MEM_BIG_ENDIAN_EN via the package.
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 32
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic [31:0] mem_writeData,
  input  logic [31:0] mem_readData,
  output logic        mem_memWrite,
  output logic        mem_memRead
);

  state_e      state_q, state_d;
  logic [31:0] resp_rdata_q, resp_rdata_d;
  logic        resp_err_q, resp_err_d;
  logic [31:0] merge_q, merge_d;
  logic [31:0] addr_q, wdata_q;
  logic [1:0]  size_q;
  logic        signed_q, write_q;
  logic        accept, acc_err;
  logic [31:0] load_data, merged;

  assign accept  = (state_q == ST_IDLE) && req_valid;
  assign acc_err = (req_size == 2'b11)
                 || ((req_size == SZ_HALF) && req_addr[0])
                 || ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00))
                 || ({2'b00, req_addr[31:2]} >= 32'(MEM_WORDS));

  mem_lane_align u_align (
    .word_i   (mem_readData),
    .addr_i   (addr_q[1:0]),
    .size_i   (size_q),
    .signed_i (signed_q),
    .wdata_i  (wdata_q),
    .load_o   (load_data),
    .merge_o  (merged)
  );

  always_comb begin
    state_d      = state_q;
    resp_rdata_d = resp_rdata_q;
    resp_err_d   = resp_err_q;
    merge_d      = merge_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          if (acc_err) begin
            state_d      = ST_RESP;
            resp_err_d   = 1'b1;
            resp_rdata_d = 32'h0;
          end else if (req_write && (req_size == SZ_WORD)) begin
            state_d = ST_WR;
          end else begin
            state_d = ST_RD;
          end
        end
      end
      ST_RD: begin
        if (write_q) begin
          merge_d = merged;
          state_d = ST_WR;
        end else begin
          resp_rdata_d = load_data;
          resp_err_d   = 1'b0;
          state_d      = ST_RESP;
        end
      end
      ST_WR: begin
        resp_rdata_d = 32'h0;
        resp_err_d   = 1'b0;
        state_d      = ST_RESP;
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and response state; reset returns to IDLE so a pending write strobe drops at once.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= ST_IDLE;
      resp_rdata_q <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      resp_rdata_q <= resp_rdata_d;
      resp_err_q   <= resp_err_d;
    end
  end

  always_ff @(posedge CLK) begin
    merge_q <= merge_d;
    if (accept) begin
      addr_q   <= req_addr;
      size_q   <= req_size;
      signed_q <= req_signed;
      write_q  <= req_write;
      wdata_q  <= req_wdata;
    end
  end

  assign req_ready     = (state_q == ST_IDLE);
  assign resp_valid    = (state_q == ST_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_err      = resp_err_q;
  assign mem_memRead   = (state_q == ST_RD);
  assign mem_memWrite  = (state_q == ST_WR);
  assign mem_address   = (mem_memRead || mem_memWrite) ? {2'b00, addr_q[31:2]} : 32'h0;
  assign mem_writeData = mem_memWrite ? ((size_q == SZ_WORD) ? wdata_q : merge_q) : 32'h0;

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator for the word-addressed 32x32 data memory: sits in the MEM stage between pipeline and memory.
- Converts byte-addressed load/store requests (byte/half/word, signed/unsigned) into word reads/writes.
- Sub-word stores are done as read-modify-write, because the memory only writes whole words.
- Provides a ready/valid stall handshake to the pipeline and a one-cycle response pulse.

Parameters:
- MEM_WORDS, 32, number of words in the data memory; word index >= MEM_WORDS is out of range.

Ports:
- CLK  input  1  clock; memory writes on posedge CLK.
- RST_N  input  1  asynchronous active-low reset.
- req_valid  input  1  pipeline presents a request.
- req_ready  output  1  unit can accept a request (high only in IDLE).
- req_write  input  1  1=store, 0=load.
- req_size  input  2  00=byte, 01=half, 10=word, 11=reserved (treated as error).
- req_signed  input  1  sign-extend sub-word loads.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned for sub-word stores.
- resp_valid  output  1  one-cycle completion pulse for loads and stores.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, reserved size or out-of-range; valid with resp_valid.
- mem_address  output  32  word index = {2'b00, addr[31:2]}.
- mem_writeData  output  32  word to write.
- mem_readData  input  32  combinational read data from memory.
- mem_memWrite  output  1  write strobe.
- mem_memRead  output  1  read enable.

Behaviour:
- Reset (async, RST_N=0):
  - state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0.
  - mem_memWrite=0, mem_memRead=0, mem_address=0, mem_writeData=0.
  - Asserting reset mid-operation drops mem_memWrite immediately, so no partial write is committed on the next edge.
- States: IDLE, RD, WR, RESP.
- Memory-side outputs are decoded from state plus captured request registers. They are 0 outside RD/WR.
  - mem_memRead=1 only in RD.
  - mem_memWrite=1 only in WR.
- IDLE:
  - Accept on a posedge with req_valid=1. Capture addr, size, signed, write, wdata.
  - Error check at accept: size=11; half with addr[0]=1; word with addr[1:0]!=0; addr[31:2] >= MEM_WORDS.
  - Error -> RESP with err=1. Memory is never touched.
  - Otherwise: load, or sub-word store -> RD; word store -> WR.
- RD:
  - Load: register the extracted and extended data into resp_rdata -> RESP.
  - Sub-word store: merge the new byte/half into mem_readData at the lane, hold it in a merge register -> WR.
- WR: mem_writeData = merged word (or req_wdata for a word store) -> RESP.
- RESP: resp_valid=1 for exactly one cycle -> IDLE. resp_rdata/resp_err hold until the next RESP.
- Latency from accept edge to resp_valid high:
  - load 2 cycles; word store 2; sub-word store 3; error 1.
- Lane selection (little-endian default):
  - byte k = bits [8k+7:8k], k = addr[1:0].
  - half at addr[1]=0 is bits [15:0]; addr[1]=1 is bits [31:16].
- Extension: signed loads replicate bit 7/15; unsigned loads zero-fill.
- req_valid in a non-IDLE state is ignored (req_ready=0). The pipeline must hold the request.
- Back-to-back requests: a new accept is possible on the edge after RESP.

Optional Feature:
- MEM_BIG_ENDIAN_EN defined: lane k = bits [31-8k:24-8k]; half at addr[1]=0 is bits [31:16].
- Undefined: little-endian mapping as above. Latency is identical either way.

Decomposition:
- Shared package mem_access_pkg:
  - state enum;
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - function lane_shift(addr, size) covering the endian macro.
- One sub-module, mem_lane_align: combinational extract/extend for loads and merge for stores. Keeps the FSM file small.

Test Plan:
- Word store: addr 0x08, data 0x12345678 -> mem_memWrite high one cycle with mem_address=2; resp_valid 2 cycles after accept, err=0.
- Byte load: mem[2]=0x12345680, lb signed addr 0x08 -> resp_rdata 0xFFFFFF80; lbu -> 0x00000080; lb addr 0x0B -> 0x00000012.
- Sub-word store on initial 0xFFFFFFFF word 5: sh addr 0x16 data 0x0000ABCD -> one RD then one WR; mem[5]=0xABCDFFFF; resp at cycle 3.
- Errors:
  - lw addr 0x06 -> resp_err=1 after 1 cycle, no mem_memRead/mem_memWrite.
  - sw addr 0x80 (word 32 >= MEM_WORDS) -> resp_err=1.
  - size=11 -> resp_err=1.
- Reset mid-WR: drop RST_N during WR -> mem_memWrite falls asynchronously, target word unchanged, req_ready=1 after release.
- Hold/stall: req_valid held high through a load -> req_ready low for RD/RESP, only one access performed per accept.
